queue_dequeue_mux: RTL and testbench
====================================

# queue_dequeue_mux

Downstream consumer of the weighted round-robin arbiter's grant. Each grant (`selector`, `selector_enb`) becomes a one-cycle pop strobe to the selected input FIFO. The block captures that FIFO's registered read data and presents it, tagged with its queue index, on a valid/ready output toward the egress buffer. It owns the single pop strobe per grant, which keeps the arbiter purely a decision stage.

## Interface
Parameters:
- `QUEUE_QUANTITY`, 4, number of input FIFOs (power of two, ≥2)
- `DATA_BITS`, 8, word width
- `SEL_BITS`, `$clog2(QUEUE_QUANTITY)`, selector width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `enb`  in  1  global enable; low blocks new pops only
- `selector`  in  SEL_BITS  queue granted by the arbiter
- `selector_enb`  in  1  grant valid this cycle
- `buf_empty`  in  QUEUE_QUANTITY  per-queue FIFO empty flags
- `fifo_data`  in  QUEUE_QUANTITY*DATA_BITS  FIFO read data; queue i at `[i*DATA_BITS +: DATA_BITS]`, valid the cycle after its pop
- `pop`  out  QUEUE_QUANTITY  one-hot read strobe, combinational, at most one bit high
- `data_out`  out  DATA_BITS  registered output word
- `queue_id_out`  out  SEL_BITS  source queue of `data_out`
- `valid_out`  out  1  output word valid
- `ready_in`  in  1  downstream accepts the word when high with `valid_out`
- `err_empty`  out  1  registered one-cycle pulse when a grant hits an empty queue

## Operation
- FSM states: IDLE, WAIT, VALID. `sel_q` register holds the latched `selector`.
- `can_pop` = `enb && selector_enb && !buf_empty[selector]`.
- IDLE:
  - If `can_pop`: `pop[selector]`=1, `sel_q`<=`selector`, go to WAIT.
  - Otherwise stay.
- WAIT:
  - `pop`=0.
  - `data_out`<=`fifo_data[sel_q]`, `queue_id_out`<=`sel_q`, `valid_out`<=1, go to VALID.
  - WAIT always completes regardless of `enb` and `selector_enb`, because the word has already left the FIFO.
- VALID:
  - `valid_out`=1. `data_out` and `queue_id_out` stay stable until the handshake.
  - `ready_in`=1 and `can_pop`: `pop[selector]`=1, `sel_q`<=`selector`, `valid_out`<=0, go to WAIT (back-to-back).
  - `ready_in`=1 and not `can_pop`: `valid_out`<=0, go to IDLE.
  - `ready_in`=0: hold; `pop`=0 regardless of grant.
- `err_empty`<=1 for one cycle when `enb && selector_enb && buf_empty[selector]` occurs in a cycle where a pop would otherwise be permitted (IDLE, or VALID with `ready_in`). No pop is issued and the state is unchanged.
- A grant arriving in WAIT, or in VALID with `ready_in`=0, is ignored and does not raise `err_empty`. The arbiter re-grants later.
- `selector` values ≥ `QUEUE_QUANTITY` cannot occur (power-of-two constraint).

## Timing
- Reset (async assert, sync release) sets: state IDLE, `sel_q`=0, `data_out`=0, `queue_id_out`=0, `valid_out`=0, `err_empty`=0. `pop` is forced to 0 while `rst` is high.
- Latency: grant with pop in cycle N → data captured at the end of N+1 → `valid_out`=1 in cycle N+2.
- Throughput: at most one word per 2 cycles (pop, wait).
- Handshake: a word transfers in a cycle where `valid_out` and `ready_in` are both high. `valid_out` never drops without a transfer, except on reset.
- Reset during WAIT or VALID discards the popped word. This loss is accepted and no recovery is attempted.
- `pop` depends combinationally on `selector`, `selector_enb`, `buf_empty`, `enb`, `ready_in` and the state. There is no combinational path from `fifo_data` to any output.

## Test plan
- Reset: hold `rst`=1 with `selector_enb`=1 and `buf_empty`=0 → `pop`=0, `valid_out`=0, `data_out`=0; deassert → `pop[selector]` may assert the same cycle.
- Single grant: `selector`=2, `selector_enb`=1 for one cycle, `fifo_data` queue 2 = 8'hA5 on the next cycle, `ready_in`=1 → `pop`=4'b0100 for exactly one cycle; two cycles later `valid_out`=1, `data_out`=8'hA5, `queue_id_out`=2 for one cycle.
- Back-to-back: continuous grants 0,1,2,3 with `ready_in`=1 → pops 0001, 0010, 0100, 1000 every second cycle; outputs arrive in the same order, each tagged with its queue id, and no cycle has two pop bits high.
- Backpressure: `ready_in`=0 for 5 cycles while the word 8'h3C from queue 1 is valid and grants continue → `data_out`, `queue_id_out` and `valid_out` stay stable and `pop`=0 throughout; on `ready_in`=1 the transfer occurs and the next pop issues in the same cycle.
- Empty grant: `selector`=3 with `buf_empty[3]`=1 in IDLE → `pop`=0, `err_empty`=1 for one cycle, state stays IDLE; with `enb`=0 → no pop and no `err_empty`.
- Reset mid-operation: assert `rst` in the WAIT cycle → all outputs return to their reset values immediately; after release no `valid_out` occurs for the lost word.

Source files
------------

// File: rtl/queue_dequeue_mux_if.sv
// Grant, FIFO-read and egress valid/ready bundle for queue_dequeue_mux.
// master is the dequeue block's view; slave is the surrounding logic's view.
interface queue_dequeue_mux_if #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8
);
    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

    logic                                enb;
    logic [SEL_BITS-1:0]                 selector;
    logic                                selector_enb;
    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic [DATA_BITS-1:0]                data_out;
    logic [SEL_BITS-1:0]                 queue_id_out;
    logic                                valid_out;
    logic                                ready_in;
    logic                                err_empty;

    modport master (
        input  enb, selector, selector_enb, buf_empty, fifo_data, ready_in,
        output pop, data_out, queue_id_out, valid_out, err_empty
    );

    modport slave (
        output enb, selector, selector_enb, buf_empty, fifo_data, ready_in,
        input  pop, data_out, queue_id_out, valid_out, err_empty
    );
endinterface

// File: rtl/queue_dequeue_mux.sv
// Turns arbiter grants into single FIFO pop strobes and presents the
// popped word, tagged with its queue index, on a valid/ready output.
module queue_dequeue_mux #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8
) (
    input  logic clk,
    input  logic rst,
    queue_dequeue_mux_if.master bus
);
    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

    state_t                    state, state_nx;
    logic [SEL_BITS-1:0]       sel_q;
    logic [DATA_BITS-1:0]      data_q;
    logic [SEL_BITS-1:0]       id_q;
    logic                      valid_q;
    logic                      err_q;
    logic [QUEUE_QUANTITY-1:0] pop_vec;
    logic                      grant;
    logic                      sel_empty;
    logic                      slot_open;
    logic                      do_pop;
    logic                      err_nx;

    assign grant     = bus.enb && bus.selector_enb;
    assign sel_empty = bus.buf_empty[bus.selector];

    always_comb begin
        state_nx  = state;
        pop_vec   = '0;
        slot_open = 1'b0;
        do_pop    = 1'b0;
        err_nx    = 1'b0;
        unique case (state)
            IDLE:  slot_open = 1'b1;
            WAIT:  slot_open = 1'b0;
            VALID: slot_open = bus.ready_in;
            default: slot_open = 1'b0;
        endcase
        // A pop is only legal when the popped word has somewhere to land.
        do_pop = slot_open && grant && !sel_empty && !rst;
        err_nx = slot_open && grant && sel_empty;
        pop_vec[bus.selector] = do_pop;
        unique case (state)
            IDLE:  if (do_pop) state_nx = WAIT;
            WAIT:  state_nx = VALID;
            VALID: if (bus.ready_in) state_nx = do_pop ? WAIT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (do_pop) sel_q <= bus.selector;
            if (state == WAIT) begin
                data_q  <= bus.fifo_data[int'(sel_q)*DATA_BITS +: DATA_BITS];
                id_q    <= sel_q;
                valid_q <= 1'b1;
            end else if (state == VALID && bus.ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.pop          = pop_vec;
    assign bus.data_out     = data_q;
    assign bus.queue_id_out = id_q;
    assign bus.valid_out    = valid_q;
    assign bus.err_empty    = err_q;
endmodule

// File: tb/tb_queue_dequeue_mux.sv
// Randomized and directed bench for queue_dequeue_mux against a
// transaction-level model of pops, in-flight words and the output slot.
module tb_queue_dequeue_mux;
    localparam int QQ = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    queue_dequeue_mux_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) bus ();

    queue_dequeue_mux #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: word in flight from a pop, and the word sitting at the output
    bit             m_pend;
    int             m_pq;
    bit             m_valid;
    logic [DB-1:0]  m_data;
    int             m_id;
    bit             m_err;
    int             words_out;
    int             pops_seen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_pq    = 0;
        m_valid = 0;
        m_data  = '0;
        m_id    = 0;
        m_err   = 0;
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit permitted, grant, empty_sel, next_err;
        logic [QQ-1:0] exp_pop;
        int sel;
        @(negedge clk);
        sel       = int'(bus.selector);
        permitted = !m_pend && (!m_valid || bus.ready_in);
        grant     = bus.enb && bus.selector_enb;
        empty_sel = bus.buf_empty[sel];
        exp_pop   = '0;
        if (permitted && grant && !empty_sel) exp_pop[sel] = 1'b1;
        check("pop", 32'(bus.pop), 32'(exp_pop));
        check("valid_out", 32'(bus.valid_out), 32'(m_valid));
        check("err_empty", 32'(bus.err_empty), 32'(m_err));
        if (m_valid) begin
            check("data_out", 32'(bus.data_out), 32'(m_data));
            check("queue_id_out", 32'(bus.queue_id_out), 32'(m_id));
        end
        next_err = permitted && grant && empty_sel;
        if (m_pend) begin
            m_valid = 1;
            m_data  = bus.fifo_data[m_pq*DB +: DB];
            m_id    = m_pq;
            m_pend  = 0;
        end else if (m_valid && bus.ready_in) begin
            m_valid = 0;
            words_out++;
        end
        if (exp_pop != '0) begin
            m_pend = 1;
            m_pq   = sel;
            pops_seen++;
        end
        m_err = next_err;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input int s, input bit se,
                         input logic [QQ-1:0] emp, input bit rdy);
        bus.enb          = e;
        bus.selector     = 2'(s);
        bus.selector_enb = se;
        bus.buf_empty    = emp;
        bus.ready_in     = rdy;
    endtask

    initial begin
        words_out = 0;
        pops_seen = 0;
        model_reset();
        bus.fifo_data = '0;
        drive(1, 2, 1, 4'b0000, 1);

        // reset holds outputs quiet despite a live grant
        repeat (3) @(posedge clk);
        #1;
        check("rst_pop", 32'(bus.pop), 0);
        check("rst_valid", 32'(bus.valid_out), 0);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_err", 32'(bus.err_empty), 0);
        rst = 1'b0;
        #1;
        check("rel_pop", 32'(bus.pop), 32'h4);

        // single grant of queue 2, word A5 one cycle later
        cycle();
        bus.selector_enb = 0;
        bus.fifo_data = '0;
        bus.fifo_data[2*DB +: DB] = 8'hA5;
        cycle();
        check("single_valid", 32'(bus.valid_out), 1);
        check("single_data", 32'(bus.data_out), 32'hA5);
        check("single_id", 32'(bus.queue_id_out), 2);
        cycle();
        check("single_drop", 32'(bus.valid_out), 0);

        // back-to-back grants 0..3
        for (int i = 0; i < 8; i++) begin
            drive(1, (i / 2) % QQ, 1, 4'b0000, 1);
            bus.fifo_data = {8'h33, 8'h22, 8'h11, 8'h00} + {4{8'(i)}};
            cycle();
        end
        drive(1, 0, 0, 4'b0000, 1);
        repeat (3) cycle();

        // backpressure on word 3C from queue 1 while grants continue
        drive(1, 1, 1, 4'b0000, 1);
        cycle();
        bus.selector_enb = 0;
        bus.fifo_data[1*DB +: DB] = 8'h3C;
        cycle();
        drive(1, 3, 1, 4'b0000, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_data", 32'(bus.data_out), 32'h3C);
            check("bp_id", 32'(bus.queue_id_out), 1);
        end
        bus.ready_in = 1;
        #1;
        check("bp_release_pop", 32'(bus.pop), 32'h8);
        cycle();
        drive(1, 0, 0, 4'b0000, 1);
        repeat (3) cycle();

        // empty grant in IDLE, then the same with enb low
        drive(1, 3, 1, 4'b1000, 1);
        cycle();
        check("empty_err", 32'(bus.err_empty), 1);
        drive(0, 3, 1, 4'b1000, 1);
        cycle();
        check("empty_err_clear", 32'(bus.err_empty), 0);
        cycle();

        // reset in the WAIT cycle discards the word
        drive(1, 1, 1, 4'b0000, 1);
        cycle();
        drive(1, 1, 0, 4'b0000, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.valid_out), 0);
        check("midrst_data", 32'(bus.data_out), 0);
        check("midrst_pop", 32'(bus.pop), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(9, 0) != 0, int'($urandom_range(QQ - 1, 0)),
                  $urandom_range(9, 0) < 7,
                  {($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
                   ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0)},
                  $urandom_range(9, 0) < 7);
            bus.fifo_data = $urandom;
            cycle();
        end
        if (pops_seen < 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL traffic: got %0d pops expected at least 100", pops_seen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
